// File: rtl/exec_unit_if.sv
// Issue/write-back bundle between control, register file ports and exec_unit.
// master = issuing control side, slave = execute stage.
interface exec_unit_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [ADDR_W-1:0] dest;
  logic              busy;
  logic              we;
  logic [ADDR_W-1:0] a3;
  logic [DATA_W-1:0] wd1;
  logic              zero;
  logic              carry;

  modport master (
    output start, op, rs1_data, rs2_data, dest,
    input  busy, we, a3, wd1, zero, carry
  );
  modport slave (
    input  start, op, rs1_data, rs2_data, dest,
    output busy, we, a3, wd1, zero, carry
  );
endinterface

// File: rtl/exec_unit.sv
// Execute stage: single-cycle logic/arith/shift ops, iterative shift-add MUL,
// drives register file write-back (wd1/a3/we) and zero/carry flags.
module exec_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic        clock,
  input  logic        reset,
  exec_unit_if.slave  eif
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010,
                         OP_OR  = 3'b011, OP_XOR = 3'b100, OP_SHL = 3'b101,
                         OP_SHR = 3'b110, OP_MUL = 3'b111;

  typedef enum logic {IDLE, MUL} state_t;

  state_t              state;
  logic [2*DATA_W-1:0] acc, mcand, acc_next;
  logic [DATA_W-1:0]   mplier;
  logic [ADDR_W-1:0]   mdest;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (eif.op)
      OP_ADD: {alu_c, alu_res} = {1'b0, eif.rs1_data} + {1'b0, eif.rs2_data};
      OP_SUB: begin
        alu_res = eif.rs1_data - eif.rs2_data;
        alu_c   = eif.rs1_data < eif.rs2_data;
      end
      OP_AND: alu_res = eif.rs1_data & eif.rs2_data;
      OP_OR:  alu_res = eif.rs1_data | eif.rs2_data;
      OP_XOR: alu_res = eif.rs1_data ^ eif.rs2_data;
      OP_SHL: {alu_c, alu_res} = {eif.rs1_data, 1'b0};
      OP_SHR: begin
        alu_res = {1'b0, eif.rs1_data[DATA_W-1:1]};
        alu_c   = eif.rs1_data[0];
      end
      default: ;
    endcase
  end

  // One partial product per cycle, selected by the multiplier bit at cnt
  assign acc_next = acc + (mplier[cnt] ? (mcand << cnt) : '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      eif.busy  <= 1'b0;
      eif.we    <= 1'b0;
      eif.a3    <= '0;
      eif.wd1   <= '0;
      eif.zero  <= 1'b0;
      eif.carry <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      mdest     <= '0;
      cnt       <= '0;
    end else begin
      eif.we <= 1'b0;
      case (state)
        IDLE: if (eif.start) begin
          if (eif.op == OP_MUL) begin
            mcand    <= {{DATA_W{1'b0}}, eif.rs1_data};
            mplier   <= eif.rs2_data;
            mdest    <= eif.dest;
            acc      <= '0;
            cnt      <= '0;
            eif.busy <= 1'b1;
            state    <= MUL;
          end else begin
            eif.wd1   <= alu_res;
            eif.a3    <= eif.dest;
            eif.we    <= 1'b1;
            eif.zero  <= (alu_res == '0);
            eif.carry <= alu_c;
          end
        end
        MUL: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          // Final iteration writes back directly so we lands right as busy drops
          if (cnt == LAST) begin
            eif.wd1   <= acc_next[DATA_W-1:0];
            eif.a3    <= mdest;
            eif.we    <= 1'b1;
            eif.zero  <= (acc_next[DATA_W-1:0] == '0);
            eif.carry <= |acc_next[2*DATA_W-1:DATA_W];
            eif.busy  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: directed cases plus randomized ops against
// an arithmetic reference model; a negedge monitor checks every write-back.
module tb_exec_unit;
  localparam int W  = 8;
  localparam int AW = 3;
  localparam int M  = 2 ** W;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  exec_unit_if #(.DATA_W(W), .ADDR_W(AW)) eif();
  exec_unit #(.DATA_W(W), .ADDR_W(AW)) dut (.clock(clock), .reset(reset), .eif(eif));

  typedef struct {int a3; int wd1; int z; int c;} wb_t;

  wb_t expq[$];
  wb_t last;
  wb_t mon_e;
  int  checks = 0;
  int  fails  = 0;
  bit  mon_en = 1'b0;

  task automatic chk(string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic wb_t model(int op, int a, int b, int d);
    wb_t e;
    int  r;
    e.a3 = d;
    e.c  = 0;
    case (op)
      0: begin r = a + b; e.c = int'(r >= M); end
      1: begin r = a - b; e.c = int'(a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = a * 2; e.c = int'(r >= M); end
      6: begin r = a / 2; e.c = a % 2; end
      default: begin r = a * b; e.c = int'(r >= M); end
    endcase
    e.wd1 = ((r % M) + M) % M;
    e.z   = int'(e.wd1 == 0);
    return e;
  endfunction

  function automatic wb_t wb(int a3, int wd1, int z, int c);
    wb_t e;
    e.a3 = a3; e.wd1 = wd1; e.z = z; e.c = c;
    return e;
  endfunction

  // Monitor: every we must match the oldest expectation; otherwise outputs hold
  always @(negedge clock) begin
    if (mon_en) begin
      if (eif.we === 1'b1) begin
        if (expq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_we: got write a3=%0d wd1=%0d, expected no write", eif.a3, eif.wd1);
        end else begin
          mon_e = expq.pop_front();
          chk("wb_a3", eif.a3, mon_e.a3);
          chk("wb_wd1", eif.wd1, mon_e.wd1);
          chk("wb_zero", eif.zero, mon_e.z);
          chk("wb_carry", eif.carry, mon_e.c);
          last = mon_e;
        end
      end else begin
        chk("we_low", eif.we, 0);
        chk("hold_a3", eif.a3, last.a3);
        chk("hold_wd1", eif.wd1, last.wd1);
        chk("hold_zero", eif.zero, last.z);
        chk("hold_carry", eif.carry, last.c);
      end
    end
  end

  // Called at a negedge with the unit idle; returns at the negedge of the we cycle
  task automatic issue(int op, int a, int b, int d, wb_t e);
    chk("busy_idle", eif.busy, 0);
    eif.start    = 1'b1;
    eif.op       = 3'(op);
    eif.rs1_data = W'(a);
    eif.rs2_data = W'(b);
    eif.dest     = AW'(d);
    expq.push_back(e);
    @(negedge clock);
    eif.start = 1'b0;
    if (op == 7) begin
      for (int k = 0; k < W; k++) begin
        chk("busy_mul", eif.busy, 1);
        eif.start    = 1'($urandom_range(0, 1));
        eif.op       = 3'($urandom);
        eif.rs1_data = W'($urandom);
        eif.rs2_data = W'($urandom);
        eif.dest     = AW'($urandom);
        @(negedge clock);
      end
      eif.start = 1'b0;
      chk("busy_done", eif.busy, 0);
    end
  endtask

  task automatic idle();
    eif.start = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    int op, a, b, d;
    last = wb(0, 0, 0, 0);
    eif.start = 1'b0; eif.op = '0; eif.rs1_data = '0; eif.rs2_data = '0; eif.dest = '0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_busy", eif.busy, 0);
    chk("rst_we", eif.we, 0);
    chk("rst_a3", eif.a3, 0);
    chk("rst_wd1", eif.wd1, 0);
    chk("rst_zero", eif.zero, 0);
    chk("rst_carry", eif.carry, 0);
    reset  = 1'b0;
    mon_en = 1'b1;

    issue(0, 200, 100, 2, wb(2, 8'h2C, 0, 1));
    idle();
    issue(1, 5, 5, 1, wb(1, 8'h00, 1, 0));
    issue(1, 3, 5, 3, wb(3, 8'hFE, 0, 1));
    idle();
    issue(5, 8'h81, 0, 4, wb(4, 8'h02, 0, 1));
    issue(6, 8'h01, 0, 5, wb(5, 8'h00, 1, 1));
    issue(4, 8'hAA, 8'hAA, 6, wb(6, 8'h00, 1, 0));
    idle();
    issue(7, 16, 17, 7, wb(7, 8'h10, 0, 1));
    idle();
    issue(7, 15, 15, 0, wb(0, 8'hE1, 0, 0));
    issue(0, 1, 1, 5, wb(5, 8'h02, 0, 0));
    issue(1, 3, 5, 2, wb(2, 8'hFE, 0, 1));
    idle();

    // MUL aborted by reset on its 4th busy cycle: no write, flags cleared
    chk("busy_idle", eif.busy, 0);
    eif.start = 1'b1; eif.op = 3'd7; eif.rs1_data = 8'hFF; eif.rs2_data = 8'hFF; eif.dest = 3'd4;
    @(negedge clock);
    eif.start = 1'b0;
    repeat (3) begin
      chk("busy_mul", eif.busy, 1);
      @(negedge clock);
    end
    chk("busy_mul", eif.busy, 1);
    reset = 1'b1;
    @(posedge clock);
    #1 last = wb(0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b0;
    chk("abort_busy", eif.busy, 0);
    chk("abort_zero", eif.zero, 0);
    chk("abort_carry", eif.carry, 0);
    repeat (12) begin
      chk("abort_we", eif.we, 0);
      @(negedge clock);
    end

    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 7 : int'($urandom_range(0, 6));
      a  = int'($urandom_range(0, M - 1));
      b  = int'($urandom_range(0, M - 1));
      if ($urandom_range(0, 7) == 0) b = a;
      d  = int'($urandom_range(0, 2 ** AW - 1));
      issue(op, a, b, d, model(op, a, b, d));
      if ($urandom_range(0, 2) == 0) idle();
    end

    repeat (3) idle();
    chk("queue_empty", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- 8-bit execute stage sitting between the register file read ports and its write port.
- Consumes the two register read operands plus an opcode and destination index.
- Computes the result and drives the register file write-back signals (wd1, a3, we) directly.
- Logic, add/sub and shift ops complete in one cycle; MUL runs as an iterative shift-add over DATA_W cycles, with a busy handshake back to the issuing control.

Parameters:
- DATA_W, 8: operand/result width. It also sets the MUL iteration count.
- ADDR_W, 3: destination register index width (8 registers).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  issue strobe; accepted only when busy=0
- op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL1, 110 SHR1, 111 MUL
- rs1_data  in  DATA_W  operand A, driven from register file rd1
- rs2_data  in  DATA_W  operand B, driven from register file rd2
- dest  in  ADDR_W  destination register index
- busy  out  1  high while a MUL is iterating; start ignored while high
- we  out  1  register file write enable, one-cycle pulse
- a3  out  ADDR_W  register file write address
- wd1  out  DATA_W  register file write data
- zero  out  1  flag: last written result == 0
- carry  out  1  flag: carry/borrow/shift-out/overflow of last op

Behaviour:
- Clocking and reset:
  - Single clock; all state changes on the rising edge of clock.
  - Reset is synchronous and active-high; it has priority over everything else.
  - Reset values: busy=0, we=0, a3=0, wd1=0, zero=0, carry=0, FSM=IDLE, accumulator and counter cleared.
- FSM states are IDLE and MUL:
  - IDLE, start=1, op!=111: on that edge compute result; register wd1=result, a3=dest, we=1, and the flags. Stay in IDLE. we is high for exactly the next cycle (latency 1).
  - IDLE, start=1, op=111: latch rs1_data, rs2_data and dest, clear the 2*DATA_W accumulator, counter=0, busy=1, go to MUL.
  - MUL: each cycle, if multiplier bit[counter] is 1, add (multiplicand << counter) to the accumulator; counter++. start is ignored and not queued.
  - MUL, after the DATA_W-th iteration: wd1=acc[DATA_W-1:0], a3=latched dest, we=1, busy=0, return to IDLE.
  - MUL timing: with accept at edge N, busy=1 in cycles N+1..N+DATA_W, and we=1 in cycle N+DATA_W+1 with busy=0.
  - A start in the we cycle of a MUL is accepted normally. This allows back-to-back issue.
- Operand capture:
  - Operands and dest are sampled only at the accepting edge.
  - Later changes on rs1_data/rs2_data/dest do not affect an in-flight MUL.
- we:
  - Deasserts after one cycle unless a new single-cycle op is accepted on that same edge.
  - Back-to-back single-cycle ops give continuous we=1 with new a3/wd1 each cycle.
  - a3/wd1 hold their last values when we=0.
- Arithmetic (modulo 2^DATA_W):
  - ADD: carry = bit DATA_W of the sum.
  - SUB: result = A-B; carry = borrow (A<B unsigned).
  - AND/OR/XOR: carry=0.
  - SHL1: carry = A[DATA_W-1].
  - SHR1 (logical): carry = A[0].
  - MUL: result = low byte of the product; carry = (high half of the product != 0).
- Flags: zero and carry update only on the edge that asserts we, and hold otherwise.
- Reset during MUL: the operation is aborted, no we pulse is produced, and busy=0 the cycle after reset.
- start with an undefined op does not exist; all 8 encodings are defined.

Test Plan:
- Reset then ADD: rs1=200, rs2=100, dest=2, start for 1 cycle -> next cycle we=1, a3=2, wd1=0x2C, carry=1, zero=0. The following cycle we=0.
- SUB pair: 5-5 to dest 1, then 3-5 to dest 3 back-to-back -> we high 2 cycles; first wd1=0x00 zero=1 carry=0; second wd1=0xFE zero=0 carry=1.
- Shifts: SHL1 of 0x81 -> wd1=0x02, carry=1; SHR1 of 0x01 -> wd1=0x00, zero=1, carry=1. XOR 0xAA^0xAA -> zero=1, carry=0.
- MUL 16*17 dest 7, accepted at edge N:
  - busy=1 in cycles N+1..N+8; start pulses during busy are ignored, with no extra we.
  - Operand inputs changed mid-op have no effect.
  - Cycle N+9: we=1, a3=7, wd1=0x10, carry=1, busy=0.
- MUL 15*15 followed by ADD 1+1 issued in the MUL's we cycle -> wd1=0xE1 carry=0, then next cycle wd1=0x02 a3=ADD dest.
- Reset asserted on the 4th busy cycle of MUL 255*255 -> next cycle busy=0; we stays 0 for 12 cycles; flags=0.
